// File: rtl/hct138_rr_arbiter.sv
// hct138_rr_arbiter
//   Eight-requester round-robin arbiter that sequences an HCT138 3-to-8
//   decoder. The decoder's active-low outputs Y0..Y7 act as one-hot grant
//   strobes. Each grant lasts until its requester releases, or until
//   HOLD_MAX cycles have passed. Every grant is followed by GAP dead cycles
//   with the decoder disabled, then one IDLE cycle in which arbitration
//   takes place.
//
// Parameters
//   HOLD_MAX  maximum grant length in cycles (1..255)
//   GAP       dead-time cycles after every grant (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req[7:0]   level request per channel
//   C, B, A    decoder select = granted channel index (registered)
//   G          decoder enable, active-high (registered)
//   G_2A/G_2B  decoder enables, active-low (registered, always equal)
//   gnt_valid  high exactly while the decoder is enabled
//   cnt[7:0]   cycles elapsed in the current grant
module hct138_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int GAP      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       G,
    output logic       G_2A,
    output logic       G_2B,
    output logic       gnt_valid,
    output logic [7:0] cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] sel, sel_nx;
    logic [7:0] cnt_q, cnt_nx;
    logic [3:0] dcnt, dcnt_nx;
    logic       en_q;
    logic       en_n_q;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    // Rotating priority scan: ptr+1 first, ptr itself last. The 3-bit add
    // wraps 7 -> 0 naturally, and k=8 truncates to ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr + 3'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        cnt_nx   = cnt_q;
        dcnt_nx  = dcnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    sel_nx   = pick_idx;
                    ptr_nx   = pick_idx;
                    cnt_nx   = 8'd0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // Release and timeout on the same cycle collapse into one
                // exit; other channels' requests are never looked at here.
                if (!req[sel] || (cnt_q == HOLD_LAST)) begin
                    state_nx = DEAD;
                    dcnt_nx  = 4'd0;
                end else if (cnt_q < HOLD_SAT) begin
                    cnt_nx = cnt_q + 8'd1;
                end
            end
            DEAD: begin
                if (dcnt == GAP_LAST) begin
                    state_nx = IDLE;
                end else begin
                    dcnt_nx = dcnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd7;
            sel   <= 3'd0;
            cnt_q <= 8'd0;
            dcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            cnt_q <= cnt_nx;
            dcnt  <= dcnt_nx;
        end
    end

    // Enables are registered from the next state so they switch on the same
    // edge as the state change. Select only changes on IDLE->GRANT, while
    // the decoder is still off, so Y never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            en_n_q <= 1'b1;
        end else begin
            en_q   <= (state_nx == GRANT);
            en_n_q <= (state_nx != GRANT);
        end
    end

    assign C         = sel[2];
    assign B         = sel[1];
    assign A         = sel[0];
    assign G         = en_q;
    assign G_2A      = en_n_q;
    assign G_2B      = en_n_q;
    assign gnt_valid = en_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_hct138_rr_arbiter.sv
module tb_hct138_rr_arbiter;

    localparam int HM = 4;
    localparam int GP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       C, B, A, G, G_2A, G_2B, gnt_valid;
    logic [7:0] cnt;

    int checks = 0;
    int passes = 0;

    // Behavioural reference: is a grant active, to whom, how many cycles it
    // has lasted, how many dead cycles remain, and who was granted last.
    bit m_on;
    int m_idx, m_last, m_elapsed, m_gap_left;

    hct138_rr_arbiter #(.HOLD_MAX(HM), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .req(req),
        .C(C), .B(B), .A(A),
        .G(G), .G_2A(G_2A), .G_2B(G_2B),
        .gnt_valid(gnt_valid), .cnt(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_vec();
        return {m_on, !m_on, !m_on, 3'(m_idx), m_on};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {G, G_2A, G_2B, C, B, A, gnt_valid};
    endfunction

    function automatic logic [7:0] exp_cnt();
        return m_on ? 8'(m_elapsed - 1) : cnt;
    endfunction

    task automatic model_reset();
        m_on = 0; m_idx = 0; m_last = 7; m_elapsed = 0; m_gap_left = 0;
    endtask

    // Apply a request, take one rising edge, advance the model, settle.
    task automatic step(input logic [7:0] r);
        bit found;
        req = r;
        @(posedge clk);
        if (m_on) begin
            if (!r[m_idx] || m_elapsed == HM) begin
                m_on = 0;
                m_gap_left = GP;
            end else begin
                m_elapsed++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (r != 8'h00) begin
            found = 0;
            for (int k = 1; k <= 8; k++) begin
                if (!found && r[(m_last + k) % 8]) begin
                    found = 1;
                    m_idx = (m_last + k) % 8;
                end
            end
            m_on = 1; m_elapsed = 1; m_last = m_idx;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req = 8'hFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec() !== 7'b0110000) $display("FAIL reset_outputs got=%b want=0110000", obs_vec());
        else passes++;
        checks++;
        if (cnt !== 8'd0) $display("FAIL reset_cnt got=%0d want=0", cnt);
        else passes++;
        rst = 1'b0;
        model_reset();
        step(8'hFF);
        checks++;
        if ({G, C, B, A} !== 4'b1000) $display("FAIL reset_first_grant got=%b want=1000", {G, C, B, A});
        else passes++;
        checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_model got=%b want=%b", obs_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_single();
        int low3;
        do_reset();
        low3 = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 3 ? 8'h08 : 8'h00);
            if (G === 1'b1 && {C, B, A} === 3'd3) low3++;
            checks++;
            if (obs_vec() !== exp_vec() || cnt !== exp_cnt())
                $display("FAIL single_cycle%0d got=%b/%0d want=%b/%0d", i, obs_vec(), cnt, exp_vec(), exp_cnt());
            else passes++;
        end
        checks++;
        if (low3 !== 3) $display("FAIL single_y3_len got=%0d want=3", low3);
        else passes++;
    endtask

    task automatic rr_run(input string name, input logic [7:0] pat, input int cycles,
                          output int order[$]);
        logic [7:0] r;
        logic prev_g;
        order = {};
        prev_g = G;
        for (int i = 0; i < cycles; i++) begin
            r = pat;
            if (m_on && m_elapsed >= 2) r = pat & ~(8'd1 << m_idx);
            step(r);
            if (G === 1'b1 && prev_g !== 1'b1) order.push_back(int'({C, B, A}));
            prev_g = G;
            checks++;
            if (obs_vec() !== exp_vec() || cnt !== exp_cnt())
                $display("FAIL %s_cycle%0d got=%b/%0d want=%b/%0d", name, i, obs_vec(), cnt, exp_vec(), exp_cnt());
            else passes++;
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int want;
        do_reset();
        rr_run("rr", 8'h81, 28, order);
        checks++;
        if (order.size() < 6) $display("FAIL rr_grant_count got=%0d want>=6", order.size());
        else passes++;
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            want = (i % 2 == 0) ? 0 : 7;
            checks++;
            if (order[i] !== want) $display("FAIL rr_order%0d got=%0d want=%0d", i, order[i], want);
            else passes++;
        end
    endtask

    task automatic test_skip();
        int order[$];
        int want[3] = '{7, 2, 5};
        do_reset();
        step(8'h20);
        checks++;
        if ({G, C, B, A} !== 4'b1101) $display("FAIL skip_setup got=%b want=1101", {G, C, B, A});
        else passes++;
        step(8'h00);
        rr_run("skip", 8'hA4, 20, order);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= order.size() || order[i] !== want[i])
                $display("FAIL skip_order%0d got=%0d want=%0d", i, (i < order.size()) ? order[i] : -1, want[i]);
            else passes++;
        end
    endtask

    task automatic test_timeout();
        logic want_on;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(8'h02);
            want_on = ((i % (HM + GP + 1)) < HM);
            checks++;
            if (G !== want_on || {C, B, A} !== 3'd1)
                $display("FAIL timeout_cycle%0d got=%b%b want=%b001", i, G, {C, B, A}, want_on);
            else passes++;
            checks++;
            if (obs_vec() !== exp_vec() || cnt !== exp_cnt())
                $display("FAIL timeout_model%0d got=%b/%0d want=%b/%0d", i, obs_vec(), cnt, exp_vec(), exp_cnt());
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'h40);
        step(8'h40);
        checks++;
        if ({G, C, B, A} !== 4'b1110) $display("FAIL areset_setup got=%b want=1110", {G, C, B, A});
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 7'b0110000 || cnt !== 8'd0)
            $display("FAIL areset_immediate got=%b/%0d want=0110000/0", obs_vec(), cnt);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(8'h40);
        checks++;
        if ({G, C, B, A} !== 4'b1110) $display("FAIL areset_regrant got=%b want=1110", {G, C, B, A});
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(7))
                0: r = 8'($urandom);
                1: r = 8'h00;
                2: r = r ^ (8'd1 << $urandom_range(7));
                default: ;
            endcase
            step(r);
            checks++;
            if (obs_vec() !== exp_vec() || cnt !== exp_cnt())
                $display("FAIL random_cycle%0d req=%h got=%b/%0d want=%b/%0d", i, r, obs_vec(), cnt, exp_vec(), exp_cnt());
            else passes++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
